// File: rtl/data_unloader_3d.sv
// Streams a DEPTH x HEIGHT x WIDTH array of signed words onto one valid/ready bus,
// depth-outer / width-inner, so the 3D bus loader rebuilds the same array.
module data_unloader_3d #(
    parameter int unsigned BUS_WIDTH = 32,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned HEIGHT    = 8,
    parameter int unsigned WIDTH     = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        abort,
    input  logic signed [BUS_WIDTH-1:0] signal_in [DEPTH][HEIGHT][WIDTH],
    output logic signed [BUS_WIDTH-1:0] out_bus,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [9:0]                  out_idx,
    output logic                        busy,
    output logic                        done
);
    localparam int unsigned IW    = (DEPTH  > 1) ? $clog2(DEPTH)  : 1;
    localparam int unsigned JW    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int unsigned KW    = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int unsigned TOTAL = DEPTH * HEIGHT * WIDTH;

    // out_idx is 10 bits wide, so the array may hold at most 1024 elements
    if (TOTAL > 1024) begin : g_size_check
        $error("data_unloader_3d: DEPTH*HEIGHT*WIDTH must not exceed 1024");
    end

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} state_t;

    state_t                 state_q, state_d;
    logic [IW-1:0]          i_q, i_d;
    logic [JW-1:0]          j_q, j_d;
    logic [KW-1:0]          k_q, k_d;
    logic signed [BUS_WIDTH-1:0] bus_d;
    logic                   valid_d, busy_d, done_d;
    logic [9:0]             idx_d;
    logic                   last_c;

    assign last_c = (i_q == IW'(DEPTH - 1)) && (j_q == JW'(HEIGHT - 1)) && (k_q == KW'(WIDTH - 1));

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            i_q       <= '0;
            j_q       <= '0;
            k_q       <= '0;
            out_bus   <= '0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            j_q       <= j_d;
            k_q       <= k_d;
            out_bus   <= bus_d;
            out_valid <= valid_d;
            out_idx   <= idx_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

    // Next-state, counter advance and next-element selection
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        bus_d   = out_bus;
        valid_d = out_valid;
        idx_d   = out_idx;
        busy_d  = busy;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d = S_STREAM;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                    bus_d   = signal_in[0][0][0];
                    idx_d   = '0;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            S_STREAM: begin
                if (abort) begin
                    state_d = S_IDLE;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                    idx_d   = '0;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                end else if (out_ready) begin
                    if (last_c) begin
                        state_d = S_DONE;
                        i_d     = '0;
                        j_d     = '0;
                        k_d     = '0;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        if (k_q == KW'(WIDTH - 1)) begin
                            k_d = '0;
                            if (j_q == JW'(HEIGHT - 1)) begin
                                j_d = '0;
                                i_d = i_q + IW'(1);
                            end else begin
                                j_d = j_q + JW'(1);
                            end
                        end else begin
                            k_d = k_q + KW'(1);
                        end
                        bus_d = signal_in[i_d][j_d][k_d];
                        idx_d = out_idx + 10'd1;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

`ifndef SYNTHESIS
    // The source array is not captured; upstream must hold it steady while streaming
    logic [TOTAL*BUS_WIDTH-1:0] flat_in;
    for (genvar d = 0; d < DEPTH; d++) begin : g_d
        for (genvar h = 0; h < HEIGHT; h++) begin : g_h
            for (genvar w = 0; w < WIDTH; w++) begin : g_w
                assign flat_in[((d*HEIGHT + h)*WIDTH + w)*BUS_WIDTH +: BUS_WIDTH] = signal_in[d][h][w];
            end
        end
    end

    a_input_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (busy && $past(busy)) |-> (flat_in == $past(flat_in)));
`endif

endmodule

// File: doc/data_unloader_3d.md
Name: data_unloader_3d

Overview:
Serializer that streams a DEPTH x HEIGHT x WIDTH array of signed words onto a single BUS_WIDTH bus using a valid/ready handshake. It is the transmit counterpart of the 3D bus loader. Element order is depth-outer, height-middle, width-inner (k fastest), so loader(unloader(A)) == A. It sits at the output of compute layers (feature maps and weights) and feeds the host/readback bus.

Parameters:
BUS_WIDTH, 32, word width of each array element and of out_bus
DEPTH, 8, outer array dimension (i)
HEIGHT, 8, middle array dimension (j)
WIDTH, 8, inner array dimension (k)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin streaming the array; honoured only in IDLE
abort  input  1  synchronous abort of an in-progress stream
signal_in  input  signed [BUS_WIDTH-1:0] [DEPTH][HEIGHT][WIDTH]  source array; upstream holds it stable while busy=1
out_bus  output  signed BUS_WIDTH  current element
out_valid  output  1  out_bus holds a valid element
out_ready  input  1  downstream accepts; a transfer occurs when out_valid && out_ready at a rising edge
out_idx  output  10  linear index of the element on out_bus, i*HEIGHT*WIDTH + j*WIDTH + k
busy  output  1  high in STREAM
done  output  1  one-cycle pulse after the final transfer

Behaviour:
- Reset (async, rst_n=0): state=IDLE; counters i/j/k=0; out_bus=0; out_valid=0; out_idx=0; busy=0; done=0. Reset asserted mid-stream discards the stream immediately, with no done pulse.
- States: IDLE, STREAM, DONE.
- IDLE: if start=1 (and abort=0) at edge N, go to STREAM and load out_bus=signal_in[0][0][0], out_idx=0, out_valid=1, busy=1. These values are visible after edge N, so latency from start to first valid is 1 cycle. If start=0, hold.
- STREAM:
  - Register out_bus/out_idx/out_valid. While out_valid && !out_ready, out_bus and out_idx hold stable.
  - On a transfer, advance the counters: k+1. When k reaches WIDTH-1, set k=0 and j+1. When j reaches HEIGHT-1, set j=0 and i+1.
  - On the same edge, load out_bus with the next element. Throughput is 1 word per cycle while out_ready=1.
  - On the transfer of the last element [DEPTH-1][HEIGHT-1][WIDTH-1], clear out_valid and busy, reset the counters to 0, and go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. A start in DONE is ignored.
- start while busy (STREAM) is ignored; the stream is not restarted.
- abort=1 in STREAM: at that edge go to IDLE, out_valid=0, busy=0, counters=0, no done pulse. abort has priority over a simultaneous transfer. abort in IDLE/DONE has no effect apart from blocking a same-cycle start.
- With out_ready held at 1, the stream occupies exactly DEPTH*HEIGHT*WIDTH valid cycles, followed by the done pulse. The default is 512 valid cycles, with done on cycle 514 counting the start edge as cycle 1.
- No arithmetic is performed; out_bus is a bit-exact copy of signed elements. out_idx is 10 bits, so DEPTH*HEIGHT*WIDTH must be <= 1024, enforced by a static assertion.
- The unloader does not snapshot signal_in. Changes to signal_in while busy are undefined by contract; a verification assertion flags them.

Test Plan:
- Full stream, ready always high: signal_in[i][j][k]=i*64+j*8+k. Pulse start -> out_valid high for 512 consecutive cycles; out_bus sequence is 0,1,...,511; out_idx matches out_bus; done pulses 1 cycle after out_idx=511 transfers; busy low afterwards.
- Backpressure: toggle out_ready 1,0,0,1 repeating -> out_bus/out_idx stable during every ready=0 cycle; no duplicated or dropped elements; the 512 words arrive in order.
- Counter wrap: capture the transfers at out_idx 7->8 and 63->64 -> elements [0][0][7],[0][1][0] then [0][7][7],[1][0][0]; values -43 at [0][0][7] and 12345 at [1][0][0] pass through sign-intact.
- Abort/start interaction: abort after 100 transfers -> out_valid=0 next cycle, no done. Re-start -> first word is [0][0][0]. A start asserted mid-stream is ignored, with out_idx continuing monotonically.
- Reset mid-stream: drop rst_n at out_idx=200 -> all outputs 0 asynchronously. Release and start -> full 512-word stream from index 0.
- Loopback: data_unloader_3d out_bus, gated by the transfer, drives the loader's in_bus/load -> the loader array equals signal_in element-for-element after done.
